// File: rtl/esc_pkg.sv
// Shared types and helpers for the exhaustive stimulus/response engine.
package esc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    APPLY   = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    EMIT    = 3'd4,
    DONE    = 3'd5
  } esc_state_e;

  localparam int MISR_W = 16;

  // Reflected Gray code of a zero-extended index.
  function automatic logic [15:0] gray_map(input logic [15:0] i);
    return i ^ (i >> 1);
  endfunction

endpackage

// File: rtl/esc_misr.sv
// 16-bit multiple-input signature register with synchronous clear and enable.
module esc_misr #(
  parameter logic [15:0] POLY  = 16'h1021,
  parameter int          DIN_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIN_W-1:0] data_i,
  output logic [15:0]      sig_o
);
  import esc_pkg::*;

  logic [MISR_W-1:0] misr_q, misr_d;

  always_comb begin
    misr_d = misr_q;
    if (clr_i) begin
      misr_d = '0;
    end else if (en_i) begin
      misr_d = {misr_q[MISR_W-2:0], 1'b0}
             ^ (misr_q[MISR_W-1] ? POLY : '0)
             ^ MISR_W'(data_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) misr_q <= '0;
    else         misr_q <= misr_d;
  end

  assign sig_o = misr_q;

endmodule

// File: rtl/exhaustive_stim_capture.sv
// Walks all 2^IN_W patterns into a combinational DUT, streams {pattern, response}
// records over valid/ready and compacts the responses into a MISR signature.
module exhaustive_stim_capture #(
  parameter int          IN_W      = 4,
  parameter int          OUT_W     = 1,
  parameter int          SETTLE    = 1,
  parameter int          GRAY      = 0,
  parameter logic [15:0] MISR_POLY = 16'h1021
) (
  input  logic                CK,
  input  logic                reset,
  input  logic                start,
  output logic [IN_W-1:0]     dut_in,
  input  logic [OUT_W-1:0]    dut_out,
  output logic                rec_valid,
  input  logic                rec_ready,
  output logic [IN_W-1:0]     rec_pattern,
  output logic [OUT_W-1:0]    rec_response,
  output logic                busy,
  output logic                done,
  output logic [15:0]         signature,
  output logic [IN_W:0]       pattern_count,
  output esc_pkg::esc_state_e state_dbg
);
  import esc_pkg::*;

  // Record stream: a record transfers on a cycle where rec_valid && rec_ready;
  // while rec_valid is high and rec_ready low, pattern, response and dut_in hold.

  localparam logic [IN_W:0] LAST_IDX = (IN_W+1)'((1 << IN_W) - 1);

  function automatic logic [IN_W-1:0] map_idx(input logic [IN_W:0] i);
    logic [15:0] w;
    w = 16'(i[IN_W-1:0]);
    if (GRAY != 0) w = gray_map(w);
    return w[IN_W-1:0];
  endfunction

  esc_state_e       state_q, state_d;
  logic [IN_W:0]    idx_q, idx_d;
  logic [IN_W-1:0]  din_q, din_d;
  logic [IN_W-1:0]  pat_q, pat_d;
  logic [OUT_W-1:0] resp_q, resp_d;
  logic [IN_W:0]    cnt_q, cnt_d;
  logic [7:0]       settle_q, settle_d;
  logic             misr_en, misr_clr;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    din_d    = din_q;
    pat_d    = pat_q;
    resp_d   = resp_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    misr_en  = 1'b0;
    misr_clr = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          idx_d    = '0;
          cnt_d    = '0;
          misr_clr = 1'b1;
          din_d    = map_idx('0);
          state_d  = APPLY;
        end
      end
      APPLY: begin
        settle_d = 8'(SETTLE);
        state_d  = (SETTLE == 0) ? CAPTURE : esc_pkg::SETTLE;
      end
      esc_pkg::SETTLE: begin
        settle_d = settle_q - 8'd1;
        if (settle_q <= 8'd1) state_d = CAPTURE;
      end
      CAPTURE: begin
        resp_d  = dut_out;
        pat_d   = din_q;
        misr_en = 1'b1;
        state_d = EMIT;
      end
      EMIT: begin
        if (rec_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            din_d   = map_idx(idx_q + 1'b1);
            state_d = APPLY;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      din_q    <= '0;
      pat_q    <= '0;
      resp_q   <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      din_q    <= din_d;
      pat_q    <= pat_d;
      resp_q   <= resp_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
    end
  end

  esc_misr #(
    .POLY  (MISR_POLY),
    .DIN_W (OUT_W)
  ) u_misr (
    .clk_i  (CK),
    .rst_ni (reset),
    .clr_i  (misr_clr),
    .en_i   (misr_en),
    .data_i (dut_out),
    .sig_o  (signature)
  );

  assign dut_in        = din_q;
  assign rec_pattern   = pat_q;
  assign rec_response  = resp_q;
  assign pattern_count = cnt_q;
  assign rec_valid     = (state_q == EMIT);
  assign done          = (state_q == DONE);
  assign busy          = (state_q == APPLY) || (state_q == esc_pkg::SETTLE) ||
                         (state_q == CAPTURE) || (state_q == EMIT);
  assign state_dbg     = state_q;

endmodule
